// File: rtl/seq_det_pkg.sv
// Shared types and constants for the configurable serial pattern detector.
package seq_det_pkg;

    // Control FSM states, binary encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Power-on configuration: pattern 1001, four bits long, overlapping matches.
    localparam logic [31:0] DEF_PATTERN = 32'h0000_0009;
    localparam int          DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, control, serial input and status bundle of the pattern detector.
// Handshake: cfg_we, start and stop are single-cycle strobes sampled on the rising
// edge; x is taken only on edges where x_valid is high and the detector is in RUN.
// There is no back-pressure; every strobe is acted on or ignored in the same edge.
interface seq_detect_ctrl_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               stop;
    logic               x_valid;
    logic               x;
    logic               busy;
    logic               match;
    logic               done;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    state_t             dbg_state;
    logic [MAX_LEN-1:0] dbg_pattern;
    logic [LEN_W-1:0]   dbg_len;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, stop, x_valid, x,
        input  busy, match, done, match_count, cfg_err,
        input  dbg_state, dbg_pattern, dbg_len
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, stop, x_valid, x,
        output busy, match, done, match_count, cfg_err,
        output dbg_state, dbg_pattern, dbg_len
    );

endinterface

// File: rtl/seq_match_core.sv
// History shift register, fill counter and length-masked pattern compare.
// hit is combinational and describes the bit being sampled on the coming edge.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample,
    input  logic               x,
    input  logic               clr,
    input  logic               clr_fill,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_new;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_new;
    logic               eq;

    // Look-ahead of history/fill after this bit, and compare of the low len bits.
    always_comb begin
        hist_new = {hist_q[MAX_LEN-2:0], x};
        fill_new = (int'(fill_q) >= MAX_LEN) ? fill_q : fill_q + 1'b1;
        eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len)) && (hist_new[i] != pattern[i])) begin
                eq = 1'b0;
            end
        end
        hit = sample && eq && (fill_new >= len);
    end

    // Shift in sampled bits; clear on a new run; drop fill after a non-overlap match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (sample) begin
            hist_q <= hist_new;
            fill_q <= clr_fill ? '0 : fill_new;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial pattern-detector controller: config registers,
// arm/disarm FSM, saturating match counter and registered status pulses.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_ctrl_if.slave bus
);

    localparam logic [MAX_LEN-1:0] RST_PATTERN = DEF_PATTERN[MAX_LEN-1:0];
    localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(DEF_LEN);

    state_t             state_q;
    state_t             state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_inc;
    logic               match_q;
    logic               done_q;
    logic               err_q;
    logic               run;
    logic               start_acc;
    logic               sample;
    logic               hit;
    logic               done_hit;
    logic               len_bad;
    logic               cfg_ok;

    assign run       = (state_q == ST_RUN);
    assign start_acc = !run && bus.start && !bus.stop;
    // A stop edge freezes the history, so the bit on that edge is never taken.
    assign sample    = run && bus.x_valid && !bus.stop;
    assign len_bad   = (int'(bus.cfg_len) < 2) || (int'(bus.cfg_len) > MAX_LEN);
    assign cfg_ok    = bus.cfg_we && !run;
    assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
    assign done_hit  = hit && (target_q != '0) && (count_q != '1) && (count_inc == target_q);

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .sample   (sample),
        .x        (bus.x),
        .clr      (start_acc),
        .clr_fill (hit && !overlap_q),
        .pattern  (pattern_q),
        .len      (len_q),
        .hit      (hit)
    );

    // Next-state: stop always wins over start; reaching the target ends the run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start && !bus.stop) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.stop)     state_d = ST_IDLE;
                else if (done_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.stop)       state_d = ST_IDLE;
                else if (bus.start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Config registers: writable outside RUN, illegal lengths rejected with cfg_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN;
            overlap_q <= DEF_OVERLAP;
            target_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= cfg_ok && len_bad;
            if (cfg_ok && !len_bad) begin
                pattern_q <= bus.cfg_pattern;
                len_q     <= bus.cfg_len;
                overlap_q <= bus.cfg_overlap;
                target_q  <= bus.cfg_target;
            end
        end
    end

    // Match accounting and registered match/done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            match_q <= hit;
            done_q  <= done_hit;
            if (start_acc)  count_q <= '0;
            else if (hit)   count_q <= count_inc;
        end
    end

    assign bus.busy        = run;
    assign bus.match       = match_q;
    assign bus.done        = done_q;
    assign bus.match_count = count_q;
    assign bus.cfg_err     = err_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_pattern = pattern_q;
    assign bus.dbg_len     = len_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: an 8-bit-counter instance for the main
// scenarios and a 2-bit-counter instance for saturation.
module tb_seq_detect_ctrl;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(8), .LEN_W(4)) bus0 ();
    seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(2), .LEN_W(4)) bus1 ();

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .LEN_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2), .LEN_W(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.cfg_we = 0; bus0.cfg_pattern = '0; bus0.cfg_len = '0; bus0.cfg_overlap = 0;
        bus0.cfg_target = '0; bus0.start = 0; bus0.stop = 0; bus0.x_valid = 0; bus0.x = 0;
        bus1.cfg_we = 0; bus1.cfg_pattern = '0; bus1.cfg_len = '0; bus1.cfg_overlap = 0;
        bus1.cfg_target = '0; bus1.start = 0; bus1.stop = 0; bus1.x_valid = 0; bus1.x = 0;
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len,
                             input logic ovl, input logic [7:0] tgt);
        bus0.cfg_we = 1; bus0.cfg_pattern = pat; bus0.cfg_len = len;
        bus0.cfg_overlap = ovl; bus0.cfg_target = tgt;
        tick();
        bus0.cfg_we = 0;
    endtask

    task automatic pulse_start(input int d);
        if (d == 0) bus0.start = 1; else bus1.start = 1;
        tick();
        bus0.start = 0; bus1.start = 0;
    endtask

    task automatic pulse_stop(input int d);
        if (d == 0) bus0.stop = 1; else bus1.stop = 1;
        tick();
        bus0.stop = 0; bus1.stop = 0;
    endtask

    // Sends n bits, first bit taken from position n-1; checks match after every edge.
    task automatic send(input int d, input logic [15:0] bits, input logic [15:0] vld,
                        input logic [15:0] exp, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            if (d == 0) begin bus0.x = bits[i]; bus0.x_valid = vld[i]; end
            else        begin bus1.x = bits[i]; bus1.x_valid = vld[i]; end
            tick();
            chk($sformatf("%s_bit%0d", tag, n - i), (d == 0) ? bus0.match : bus1.match, exp[i]);
        end
        bus0.x_valid = 0; bus1.x_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset and reset values.
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_busy", bus0.busy, 0);
        chk("rst_match", bus0.match, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_count", bus0.match_count, 0);
        chk("rst_cfg_err", bus0.cfg_err, 0);
        chk("rst_state", bus0.dbg_state, ST_IDLE);
        chk("rst_pattern", bus0.dbg_pattern, 8'h09);
        chk("rst_len", bus0.dbg_len, 4);

        // Default config, overlapping: 1001001 matches after bits 4 and 7.
        pulse_start(0);
        chk("t1_busy", bus0.busy, 1);
        chk("t1_state", bus0.dbg_state, ST_RUN);
        send(0, 16'b1001001, 16'b1111111, 16'b0001001, 7, "t1");
        chk("t1_count", bus0.match_count, 2);

        // Non-overlapping: only the first 1001 counts.
        pulse_stop(0);
        chk("t2_stop_busy", bus0.busy, 0);
        chk("t2_stop_count", bus0.match_count, 2);
        cfg_write(8'h09, 4'd4, 1'b0, 8'd0);
        chk("t2_cfg_err", bus0.cfg_err, 0);
        pulse_start(0);
        chk("t2_start_count", bus0.match_count, 0);
        send(0, 16'b1001001, 16'b1111111, 16'b0001000, 7, "t2");
        chk("t2_count", bus0.match_count, 1);

        // Target 3 with pattern 11: done on the third match, then DONE ignores bits.
        pulse_stop(0);
        cfg_write(8'h03, 4'd2, 1'b1, 8'd3);
        pulse_start(0);
        send(0, 16'b1111, 16'b1111, 16'b0111, 4, "t3");
        chk("t3_done", bus0.done, 1);
        chk("t3_busy", bus0.busy, 0);
        chk("t3_state", bus0.dbg_state, ST_DONE);
        chk("t3_count", bus0.match_count, 3);
        send(0, 16'b11, 16'b11, 16'b00, 2, "t3_post");
        chk("t3_post_done", bus0.done, 0);
        chk("t3_post_count", bus0.match_count, 3);
        chk("t3_post_state", bus0.dbg_state, ST_DONE);

        // Illegal lengths rejected from DONE; writes during RUN ignored silently.
        cfg_write(8'h09, 4'd1, 1'b1, 8'd0);
        chk("t4_len1_err", bus0.cfg_err, 1);
        chk("t4_len1_len", bus0.dbg_len, 2);
        cfg_write(8'h09, 4'd9, 1'b1, 8'd0);
        chk("t4_len9_err", bus0.cfg_err, 1);
        chk("t4_len9_len", bus0.dbg_len, 2);
        chk("t4_len9_pat", bus0.dbg_pattern, 8'h03);
        tick();
        chk("t4_err_clear", bus0.cfg_err, 0);
        pulse_start(0);
        chk("t4_restart_busy", bus0.busy, 1);
        chk("t4_restart_count", bus0.match_count, 0);
        cfg_write(8'h09, 4'd4, 1'b1, 8'd0);
        chk("t4_run_err", bus0.cfg_err, 0);
        chk("t4_run_len", bus0.dbg_len, 2);
        chk("t4_run_pat", bus0.dbg_pattern, 8'h03);

        // start+stop together stays IDLE; x_valid gaps inside a pattern.
        pulse_stop(0);
        bus0.start = 1; bus0.stop = 1;
        tick();
        bus0.start = 0; bus0.stop = 0;
        chk("t5_ss_state", bus0.dbg_state, ST_IDLE);
        chk("t5_ss_busy", bus0.busy, 0);
        cfg_write(8'h09, 4'd4, 1'b1, 8'd0);
        chk("t5_cfg_len", bus0.dbg_len, 4);
        pulse_start(0);
        send(0, 16'b110011, 16'b101101, 16'b000001, 6, "t5_gap");
        chk("t5_gap_count", bus0.match_count, 1);
        send(0, 16'b00, 16'b11, 16'b00, 2, "t5_pre");
        bus0.x = 1; bus0.x_valid = 1; bus0.stop = 1;
        tick();
        bus0.x_valid = 0; bus0.stop = 0;
        chk("t5_stop_match", bus0.match, 0);
        chk("t5_stop_busy", bus0.busy, 0);
        chk("t5_stop_count", bus0.match_count, 1);

        // 2-bit counter saturates at 3 while match pulses keep coming.
        pulse_start(1);
        send(1, 16'b1001001001001001, 16'hFFFF, 16'b0001001001001001, 16, "t6_sat");
        chk("t6_sat_count", bus1.match_count, 3);
        chk("t6_sat_busy", bus1.busy, 1);

        // Asynchronous reset mid-run restores outputs and config.
        cfg_write(8'h05, 4'd3, 1'b0, 8'd7);
        pulse_start(0);
        send(0, 16'b101, 16'b111, 16'b001, 3, "t6_m");
        chk("t6_m_count", bus0.match_count, 1);
        rst = 1;
        #1;
        chk("t6_rst_busy", bus0.busy, 0);
        chk("t6_rst_match", bus0.match, 0);
        chk("t6_rst_count", bus0.match_count, 0);
        chk("t6_rst_state", bus0.dbg_state, ST_IDLE);
        chk("t6_rst_pattern", bus0.dbg_pattern, 8'h09);
        chk("t6_rst_len", bus0.dbg_len, 4);
        chk("t6_rst_b1_busy", bus1.busy, 0);
        chk("t6_rst_b1_count", bus1.match_count, 0);
        tick();
        rst = 0;
        pulse_start(0);
        send(0, 16'b1001, 16'b1111, 16'b0001, 4, "t6_post");
        chk("t6_post_count", bus0.match_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
